demux14: RTL and testbench

DEMUX14 -- requirements
Module: demux14

---
 rtl/demux14_pkg.sv | 14 +
 rtl/demux14_slot.sv | 47 ++++
 rtl/demux14.sv | 95 +++++++++
 tb/tb_demux14.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/demux14_pkg.sv
// Shared constants and slot state encoding for the demux14 1-to-4 demultiplexer.
// Build option: DEMUX14_COUNT_EN adds per-channel accept counters to demux14.
package demux14_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int NUM_CH    = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux14_slot.sv
// One-entry output slot: holds a word until the downstream consumer takes it.
// The current slot state is exported on the state port.
module demux14_slot
  import demux14_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output slot_state_t      state
);

  slot_state_t state_q, state_d;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) data_q <= wr_data;
    end
  end

  // A write into a FULL slot only arrives together with a drain, so it stays FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (wr_en) state_d = SLOT_FULL;
      SLOT_FULL:  if (ready && !wr_en) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    valid = (state_q == SLOT_FULL);
    data  = data_q;
    state = state_q;
  end

endmodule

// File: rtl/demux14.sv
// 1-to-4 demultiplexer with a one-entry slot per channel, routed by {s0,s1}.
// Build option: DEMUX14_COUNT_EN adds cnt0..cnt3 accept counters.
module demux14
  import demux14_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3
`ifdef DEMUX14_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  // Handshake: a word moves on any rising edge where valid && ready are both 1
  // (in_valid/in_ready upstream, vN/rN downstream); valid never waits on ready,
  // and a valid word with its data is held unchanged until it is taken.

  logic [1:0]       sel;
  logic             accept;
  logic [NUM_CH-1:0] rdy_vec;
  logic [NUM_CH-1:0] wr_vec;
  logic [NUM_CH-1:0] vld_vec;
  logic [WIDTH-1:0] y_arr [NUM_CH];
  slot_state_t      st_arr [NUM_CH];

  assign sel     = {s0, s1};
  assign rdy_vec = {r3, r2, r1, r0};

  // Refill of a FULL slot is allowed in the same cycle it drains.
  assign in_ready = (st_arr[sel] == SLOT_EMPTY) || rdy_vec[sel];
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    assign wr_vec[i] = accept && (sel == 2'(i));
    demux14_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_vec[i]),
      .wr_data (din),
      .ready   (rdy_vec[i]),
      .data    (y_arr[i]),
      .valid   (vld_vec[i]),
      .state   (st_arr[i])
    );
  end

  assign y0 = y_arr[0];
  assign y1 = y_arr[1];
  assign y2 = y_arr[2];
  assign y3 = y_arr[3];
  assign v0 = vld_vec[0];
  assign v1 = vld_vec[1];
  assign v2 = vld_vec[2];
  assign v3 = vld_vec[3];

`ifdef DEMUX14_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst)            cnt_q[i] <= '0;
      else if (wr_vec[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux14.sv
// Directed self-checking bench for demux14 (optionally with DEMUX14_COUNT_EN).
module tb_demux14;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             s0, s1;
  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic             v0, v1, v2, v3;
  logic             r0, r1, r2, r3;
`ifdef DEMUX14_COUNT_EN
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux14 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0       (s0),
    .s1       (s1),
    .din      (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .v0       (v0),
    .v1       (v1),
    .v2       (v2),
    .v3       (v3),
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3)
`ifdef DEMUX14_COUNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [WIDTH-1:0] d);
    {s0, s1} = ch;
    din      = d;
    in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; s0 = 1'b0; s1 = 1'b0; din = 8'hFF; in_valid = 1'b1;
    {r3, r2, r1, r0} = 4'b1111;

    // Reset held two cycles with in_valid asserted
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_v", {28'd0, v3, v2, v1, v0}, 32'h0);
    chk("rst_y", {y3, y2, y1, y0}, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Routing to channel 2
    send(2'b10, 8'hA5);
    #1;
    chk("route_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("route_y2", 32'(y2), 32'hA5);
    chk("route_v", {28'd0, v3, v2, v1, v0}, 32'h4);
    tick();
    chk("route_drain_v2", 32'(v2), 32'h0);
    chk("route_hold_y2", 32'(y2), 32'hA5);

    // Backpressure on channel 1
    r1 = 1'b0;
    send(2'b01, 8'h3C);
    tick();
    chk("bp_fill_v1", 32'(v1), 32'h1);
    chk("bp_fill_y1", 32'(y1), 32'h3C);
    send(2'b01, 8'h77);
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'h0);
    tick();
    chk("bp_hold_y1", 32'(y1), 32'h3C);
    chk("bp_hold_v1", 32'(v1), 32'h1);
    r1 = 1'b1;
    #1;
    chk("bp_passthru_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0; r1 = 1'b0;
    chk("bp_refill_y1", 32'(y1), 32'h77);
    chk("bp_refill_v1", 32'(v1), 32'h1);
    r1 = 1'b1;
    tick();
    chk("bp_drain_v1", 32'(v1), 32'h0);

    // Independence: ch0 stalled, ch3 still accepts
    r0 = 1'b0;
    send(2'b00, 8'h5A);
    tick();
    chk("ind_v0_full", 32'(v0), 32'h1);
    send(2'b11, 8'h11);
    #1;
    chk("ind_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("ind_v3", 32'(v3), 32'h1);
    chk("ind_y3", 32'(y3), 32'h11);
    chk("ind_v0", 32'(v0), 32'h1);
    chk("ind_y0", 32'(y0), 32'h5A);
    tick();
    chk("ind_v3_drained", 32'(v3), 32'h0);
    chk("ind_v0_stalled", 32'(v0), 32'h1);

    // Reset mid-operation discards stalled ch2 (and ch0)
    r2 = 1'b0;
    send(2'b10, 8'hC3);
    tick();
    in_valid = 1'b0;
    chk("midrst_v2_full", 32'(v2), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; r2 = 1'b1;
    chk("midrst_v", {28'd0, v3, v2, v1, v0}, 32'h0);
    chk("midrst_y2", 32'(y2), 32'h0);
    chk("midrst_y0", 32'(y0), 32'h0);
    tick();
    chk("midrst_no_emit_v2", 32'(v2), 32'h0);

`ifdef DEMUX14_COUNT_EN
    // Counter wrap on ch0 with r0 high so every cycle accepts
    r0 = 1'b1;
    send(2'b00, 8'h00);
    for (int i = 0; i < 255; i++) begin
      din = 8'(i);
      tick();
    end
    chk("cnt0_255", 32'(cnt0), 32'hFF);
    tick();
    in_valid = 1'b0;
    chk("cnt0_wrap", 32'(cnt0), 32'h0);
    chk("cnt_others", {8'd0, cnt3, cnt2, cnt1}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
